game_state_ctrl: RTL and testbench

//  Top-level round/match sequencer for the light-cycle game; the consumer end of the score

---
 rtl/game_state_ctrl.sv | 155 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Round/match sequencer for the light-cycle game. It drives the game state, score reset,
// reposition pulses, the freeze flag and the HUD countdown digit.
`timescale 1ns/1ps
module game_state_ctrl #(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned PAUSE_FRAMES     = 120,
  parameter int unsigned FRAMES_PER_DIGIT = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       reset_round,
  input  logic       Blue_W,
  input  logic       Red_W,
  output logic [2:0] Game_State,
  output logic       Reset_Score,
  output logic       round_pos_rst,
  output logic       freeze,
  output logic [1:0] countdown,
  output logic [1:0] winner
);

  localparam int unsigned MaxFrames =
      (COUNTDOWN_FRAMES > PAUSE_FRAMES) ? COUNTDOWN_FRAMES : PAUSE_FRAMES;
  localparam int unsigned CntW      = $clog2(MaxFrames) + 1;
  localparam int unsigned Digit2Lim = 2 * FRAMES_PER_DIGIT;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StTitle     = 3'd0,
    StReady     = 3'd1,
    StPlay      = 3'd2,
    StRoundOver = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d, count_inc;
  logic [2:0]      frame_sync_q, key_sync_q;
  logic            frame_tick, start_evt;
  logic            pos_rst_q, pos_rst_d;
  logic            freeze_q, freeze_d;
  logic            reset_score_q, reset_score_d;
  logic [1:0]      countdown_q, countdown_d;
  logic [1:0]      winner_q, winner_d;

  // Bits [1:0] synchronise the level; bit 2 is the previous synchronised value for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_q <= '0;
      key_sync_q   <= '0;
    end else begin
      frame_sync_q <= {frame_sync_q[1:0], frame_clk};
      key_sync_q   <= {key_sync_q[1:0], start_key};
    end
  end

  assign frame_tick = frame_sync_q[1] & ~frame_sync_q[2];
  assign start_evt  = key_sync_q[1] & ~key_sync_q[2];

  always_comb begin
    count_inc = count_q;
    if (frame_tick && (count_q != CntMax)) begin
      count_inc = count_q + CntW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_rst_d = 1'b0;
    winner_d  = winner_q;
    case (state_q)
      StTitle: begin
        if (start_evt) begin
          state_d   = StReady;
          pos_rst_d = 1'b1;
          winner_d  = 2'b00;
        end
      end
      StReady: begin
        if (32'(count_inc) >= COUNTDOWN_FRAMES) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (Blue_W || Red_W) begin
          state_d  = StGameOver;
          winner_d = {Red_W, Blue_W};
        end else if (reset_round) begin
          state_d = StRoundOver;
        end
      end
      StRoundOver: begin
        // The deciding crash raises the win flag one cycle after reset_round.
        if (Blue_W || Red_W) begin
          state_d  = StGameOver;
          winner_d = {Red_W, Blue_W};
        end else if (32'(count_inc) >= PAUSE_FRAMES) begin
          state_d   = StReady;
          pos_rst_d = 1'b1;
        end
      end
      StGameOver: begin
        if (start_evt) begin
          state_d = StTitle;
        end
      end
      default: state_d = StTitle;
    endcase

    count_d = (state_d != state_q) ? '0 : count_inc;

    freeze_d      = (state_d != StPlay);
    reset_score_d = (state_d == StTitle);
    countdown_d   = 2'd0;
    if (state_d == StReady) begin
      if (32'(count_d) >= Digit2Lim) begin
        countdown_d = 2'd1;
      end else if (32'(count_d) >= FRAMES_PER_DIGIT) begin
        countdown_d = 2'd2;
      end else begin
        countdown_d = 2'd3;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StTitle;
      count_q       <= '0;
      pos_rst_q     <= 1'b0;
      freeze_q      <= 1'b1;
      reset_score_q <= 1'b1;
      countdown_q   <= 2'd0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      pos_rst_q     <= pos_rst_d;
      freeze_q      <= freeze_d;
      reset_score_q <= reset_score_d;
      countdown_q   <= countdown_d;
      winner_q      <= winner_d;
    end
  end

  assign Game_State    = state_q;
  assign Reset_Score   = reset_score_q;
  assign round_pos_rst = pos_rst_q;
  assign freeze        = freeze_q;
  assign countdown     = countdown_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed-plus-random bench for game_state_ctrl; expected values come from a small
// event-level model of the round/match rules.
`timescale 1ns/1ps
module tb_game_state_ctrl;

  localparam int CD  = 180;
  localparam int PF  = 120;
  localparam int FPD = 60;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_clk, start_key, reset_round, Blue_W, Red_W;
  logic [2:0] Game_State;
  logic       Reset_Score, round_pos_rst, freeze;
  logic [1:0] countdown, winner;

  int n_chk  = 0;
  int n_pass = 0;

  game_state_ctrl #(
    .COUNTDOWN_FRAMES(CD),
    .PAUSE_FRAMES    (PF),
    .FRAMES_PER_DIGIT(FPD)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .start_key    (start_key),
    .reset_round  (reset_round),
    .Blue_W       (Blue_W),
    .Red_W        (Red_W),
    .Game_State   (Game_State),
    .Reset_Score  (Reset_Score),
    .round_pos_rst(round_pos_rst),
    .freeze       (freeze),
    .countdown    (countdown),
    .winner       (winner)
  );

  always #10 Clk = ~Clk;

  // Model: countdown digit is 3 minus whole digit periods elapsed, clamped to 1..3.
  function automatic int exp_cd(input int ticks);
    int d;
    d = 3 - ticks / FPD;
    if (d < 1) d = 1;
    if (d > 3) d = 3;
    return d;
  endfunction

  function automatic int exp_winner(input bit blue, input bit red);
    return (red ? 2 : 0) + (blue ? 1 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Frame strobe: low for a random gap, then high long enough to be counted.
  task automatic tick();
    frame_clk = 1'b0;
    cyc($urandom_range(2, 5));
    frame_clk = 1'b1;
    cyc(3);
  endtask

  // Key press: release first, then press and keep holding.
  task automatic press();
    start_key = 1'b0;
    cyc(3);
    start_key = 1'b1;
    cyc(3);
  endtask

  task automatic check_ready_entry(input string tag);
    check({tag, "_state"}, Game_State, 1);
    check({tag, "_pos_rst"}, round_pos_rst, 1);
    check({tag, "_cd"}, countdown, 3);
    check({tag, "_freeze"}, freeze, 1);
    cyc(1);
    check({tag, "_pos_rst_off"}, round_pos_rst, 0);
  endtask

  task automatic run_ready(input string tag);
    for (int i = 1; i <= CD; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       reset_round = 1'b1;
          1:       Blue_W = 1'b1;
          default: Red_W = 1'b1;
        endcase
        cyc(1);
        reset_round = 1'b0;
        Blue_W      = 1'b0;
        Red_W       = 1'b0;
        check({tag, "_ready_ignore"}, Game_State, 1);
      end
      tick();
      if (i < CD) begin
        check({tag, "_cd"}, countdown, exp_cd(i));
      end else begin
        check({tag, "_play_state"}, Game_State, 2);
        check({tag, "_play_freeze"}, freeze, 0);
        check({tag, "_play_cd"}, countdown, 0);
      end
    end
  endtask

  task automatic run_pause(input string tag);
    for (int i = 1; i <= PF; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset_round = 1'b1;
        cyc(1);
        reset_round = 1'b0;
        check({tag, "_rr_ignore"}, Game_State, 3);
      end
      tick();
      if (i < PF) begin
        check({tag, "_pause_state"}, Game_State, 3);
      end
    end
    check_ready_entry({tag, "_rearm"});
  endtask

  initial begin
    bit blue, red, direct;
    int start_kind, kind;
    Reset_n     = 1'b1;
    frame_clk   = 1'b0;
    start_key   = 1'b0;
    reset_round = 1'b0;
    Blue_W      = 1'b0;
    Red_W       = 1'b0;
    #5 Reset_n  = 1'b0;
    cyc(3);
    check("rst_state", Game_State, 0);
    check("rst_reset_score", Reset_Score, 1);
    check("rst_freeze", freeze, 1);
    check("rst_pos_rst", round_pos_rst, 0);
    check("rst_cd", countdown, 0);
    check("rst_winner", winner, 0);
    Reset_n = 1'b1;
    repeat (6) tick();
    check("idle_state", Game_State, 0);
    check("idle_reset_score", Reset_Score, 1);
    check("idle_freeze", freeze, 1);

    press();
    check_ready_entry("start");
    check("start_reset_score", Reset_Score, 0);
    run_ready("r1");

    repeat (3) tick();
    check("play_ticks_state", Game_State, 2);
    reset_round = 1'b1;
    cyc(1);
    reset_round = 1'b0;
    check("crash_state", Game_State, 3);
    check("crash_freeze", freeze, 1);
    run_pause("p1");
    run_ready("r2");

    start_kind = $urandom_range(0, 2);
    for (int it = 0; it < 3; it++) begin
      kind   = (start_kind + it) % 3;
      blue   = (kind != 1);
      red    = (kind != 0);
      direct = ($urandom_range(0, 3) == 0);
      if (direct) begin
        Blue_W = blue;
        Red_W  = red;
        cyc(1);
      end else begin
        reset_round = 1'b1;
        cyc(1);
        reset_round = 1'b0;
        check("win_round_over", Game_State, 3);
        Blue_W = blue;
        Red_W  = red;
        cyc(1);
      end
      check("win_state", Game_State, 4);
      check("win_winner", winner, exp_winner(blue, red));
      cyc(1);
      Blue_W = 1'b0;
      Red_W  = 1'b0;
      cyc(20);
      check("held_key_state", Game_State, 4);
      check("held_winner", winner, exp_winner(blue, red));
      if (it < 2) begin
        press();
        check("go_title_state", Game_State, 0);
        check("go_title_reset_score", Reset_Score, 1);
        check("go_title_winner", winner, exp_winner(blue, red));
        press();
        check_ready_entry("newgame");
        check("newgame_winner", winner, 0);
      end else begin
        start_key = 1'b0;
        cyc(3);
        Reset_n = 1'b0;
        #1;
        check("go_rst_state", Game_State, 0);
        check("go_rst_winner", winner, 0);
        cyc(1);
        Reset_n = 1'b1;
        cyc(2);
        press();
        check_ready_entry("after_rst");
      end
      run_ready("rw");
    end

    reset_round = 1'b1;
    cyc(1);
    reset_round = 1'b0;
    repeat ($urandom_range(10, 100)) tick();
    check("mid_pause_state", Game_State, 3);
    start_key = 1'b0;
    cyc(3);
    Reset_n = 1'b0;
    #1;
    check("mid_rst_state", Game_State, 0);
    check("mid_rst_reset_score", Reset_Score, 1);
    check("mid_rst_freeze", freeze, 1);
    check("mid_rst_pos_rst", round_pos_rst, 0);
    check("mid_rst_cd", countdown, 0);
    check("mid_rst_winner", winner, 0);
    cyc(1);
    Reset_n = 1'b1;
    cyc(2);
    press();
    check_ready_entry("final");
    for (int i = 1; i <= FPD; i++) begin
      tick();
      check("final_cd", countdown, exp_cd(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
